step_ram_arbiter: RTL and testbench
===================================

// Module: step_ram_arbiter
// PURPOSE
//  Shares the Step RAM (1 write port, 2 read ports) between three requesters:
//  0 = I/O loader, 1 = Step_Module, 2 = Interpolator.
//  Round-robin, lock-until-release grant with a one-cycle turnaround between owners.
//  Tags read returns with the owner, so data reaches the correct requester even
//  after the grant has moved. Sits between the coordinator's requesters and the RAM instance.
// PARAMETERS
//  RAM_ADDRESS_WIDTH  13   address width of every RAM port
//  DATA_WIDTH         64   RAM word width
//  RD_LATENCY         1    RAM clock-to-read-data latency in cycles (>=1)
//  MAX_HOLD           1024 grant cycles allowed while another requester waits
// PORTS
//  CLK            in   1       single clock; all state on the rising edge
//  RST            in   1       asynchronous, active-low reset
//  Req            in   3       per-requester request, level; held for the whole burst
//  Grant          out  3       one-hot (or zero) grant
//  Req_WR_Enable  in   3       per-requester write enable
//  Req_WR_Address in   3*AW    concatenated; requester k at [k*AW +: AW]
//  Req_WR_Data    in   3*DW    concatenated write data
//  Req_RD1_Address in  3*AW    concatenated read-port-1 addresses
//  Req_RD2_Address in  3*AW    concatenated read-port-2 addresses
//  RD_Valid       out  3       per-requester pulse: RAM read data belongs to k this cycle
//  RAM_WR_Enable  out  1       to RAM
//  RAM_WR_Address out  AW      to RAM
//  RAM_WR_Data    out  DW      to RAM
//  RAM_RD1_Address out AW      to RAM
//  RAM_RD2_Address out AW      to RAM
//  Hold_Timeout   out  1       sticky: an owner exceeded MAX_HOLD while others waited
//  Illegal_Access out  1       sticky: WR_Enable seen from a requester without grant
// BEHAVIOUR
//  Reset (RST=0, async): state IDLE; Grant, RD_Valid, RAM_* and both flags = 0;
//   round-robin pointer = 0; tag pipeline cleared. All outputs are registered.
//  FSM states:
//   IDLE: if any Req, grant the first requester at or after the pointer (mod 3).
//    Grant is registered, so it rises the cycle after Req is sampled. Go to OWN.
//   OWN: Grant[k] = 1 while Req[k] = 1. When Req[k] is sampled 0, drop Grant,
//    set pointer = k+1 (mod 3) and go to IDLE.
//    IDLE always lasts exactly one cycle (turnaround), so two owners are never
//    granted back to back.
//  Datapath:
//   - While Grant[k] = 1, RAM_* outputs are registered copies of requester k's fields.
//   - RAM_WR_Enable = Req_WR_Enable[k] & Grant[k].
//   - In IDLE, RAM_WR_Enable = 0 and all addresses/data = 0.
//   - Requests from non-owners never reach the RAM.
//  Read tagging:
//   - Each OWN cycle pushes the owner id into an RD_LATENCY-deep shift pipe
//     (an IDLE cycle pushes 'none').
//   - RD_Valid[k] = 1 exactly when the pipe output is k.
//   - Returns are still delivered after ownership changes.
//  Hold counter:
//   - Counts OWN cycles; clears on each new grant.
//   - Saturates at MAX_HOLD.
//   - Sets Hold_Timeout when it reaches MAX_HOLD while any other Req is high.
//   - No preemption: the owner keeps the grant.
//  Illegal_Access: set when Req_WR_Enable[j] = 1 and Grant[j] = 0 in the same cycle.
//   The write is dropped.
//  Both flags are cleared only by reset.
//  Simultaneous Req: round-robin order decides. Req rising during turnaround is
//   sampled in IDLE as usual.
//  Req dropped and re-raised by the owner: it loses priority to other waiting
//   requesters (pointer has advanced).
//  Reset mid-burst: all outputs clear immediately; in-flight reads return with
//   no RD_Valid.
// STRUCTURE
//  Shared package step_pkg:
//   - REQ_IO = 0, REQ_STEP = 1, REQ_INTERP = 2; NUM_REQ = 3
//   - state encoding ST_IDLE, ST_OWN
//   - RAM_ADDRESS_WIDTH and DATA_WIDTH defaults
//  One sub-module: rr_pick3 (combinational round-robin picker: req[2:0],
//  ptr[1:0] -> one-hot grant). Everything else stays in this module.
// TESTING
//  1. Reset: hold RST=0 3 cycles with Req=3'b111 -> Grant=0, RAM_WR_Enable=0,
//     flags=0; first Grant after release is 3'b001.
//  2. Single owner:
//     - Req[1] high 4 cycles, writes 0xA5 to address 5, then reads address 5
//       -> Grant[1] one cycle after Req.
//     - RAM sees addr 5 / data 0xA5; RD_Valid[1] pulses RD_LATENCY cycles
//       after the read.
//  3. Contention: Req=3'b111 held; each owner drops Req after 2 cycles
//     -> grant order 0,1,2,0 with exactly one IDLE cycle between grants.
//  4. Late returns: owner 2 issues a read in its last OWN cycle, RD_LATENCY=2
//     -> RD_Valid[2] fires after Grant moves to 0; RD_Valid[0] does not.
//  5. Illegal write: Req_WR_Enable[2]=1 while Grant=3'b010 -> RAM_WR_Enable
//     stays 0 and Illegal_Access=1, held until reset.
//  6. Timeout: MAX_HOLD=8, owner 0 holds 10 cycles while Req[1]=1
//     -> Hold_Timeout sets on cycle 8; Grant[0] is unchanged.

Source files
------------

// File: rtl/step_ram_arbiter_pkg.sv
// Shared definitions for the Step RAM arbiter: requester ids, FSM encoding,
// default RAM geometry and small id/one-hot conversion helpers.
package step_pkg;

   localparam int NUM_REQ                = 3;
   localparam int STEP_RAM_ADDRESS_WIDTH = 13;
   localparam int STEP_DATA_WIDTH        = 64;

   localparam logic [1:0] REQ_IO     = 2'd0;
   localparam logic [1:0] REQ_STEP   = 2'd1;
   localparam logic [1:0] REQ_INTERP = 2'd2;
   localparam logic [1:0] TAG_NONE   = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   function automatic logic [1:0] onehot_to_id(input logic [2:0] onehot);
      logic [1:0] id;
      case (onehot)
         3'b001:  id = REQ_IO;
         3'b010:  id = REQ_STEP;
         3'b100:  id = REQ_INTERP;
         default: id = REQ_IO;
      endcase
      return id;
   endfunction

   function automatic logic [2:0] tag_to_onehot(input logic [1:0] tag);
      logic [2:0] onehot;
      case (tag)
         REQ_IO:     onehot = 3'b001;
         REQ_STEP:   onehot = 3'b010;
         REQ_INTERP: onehot = 3'b100;
         default:    onehot = 3'b000;
      endcase
      return onehot;
   endfunction

   function automatic logic [1:0] next_id(input logic [1:0] id);
      logic [1:0] nxt;
      case (id)
         REQ_IO:   nxt = REQ_STEP;
         REQ_STEP: nxt = REQ_INTERP;
         default:  nxt = REQ_IO;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/step_ram_arbiter_if.sv
// Requester and RAM side bundle of the Step RAM arbiter; per-requester fields
// are concatenated, requester k at [k*W +: W].
interface step_ram_arbiter_if #(
   parameter int RAM_ADDRESS_WIDTH = 13,
   parameter int DATA_WIDTH        = 64
);
   logic [2:0]                     Req;
   logic [2:0]                     Grant;
   logic [2:0]                     Req_WR_Enable;
   logic [3*RAM_ADDRESS_WIDTH-1:0] Req_WR_Address;
   logic [3*DATA_WIDTH-1:0]        Req_WR_Data;
   logic [3*RAM_ADDRESS_WIDTH-1:0] Req_RD1_Address;
   logic [3*RAM_ADDRESS_WIDTH-1:0] Req_RD2_Address;
   logic [2:0]                     RD_Valid;
   logic                           RAM_WR_Enable;
   logic [RAM_ADDRESS_WIDTH-1:0]   RAM_WR_Address;
   logic [DATA_WIDTH-1:0]          RAM_WR_Data;
   logic [RAM_ADDRESS_WIDTH-1:0]   RAM_RD1_Address;
   logic [RAM_ADDRESS_WIDTH-1:0]   RAM_RD2_Address;
   logic                           Hold_Timeout;
   logic                           Illegal_Access;

   modport master (
      output Req, Req_WR_Enable, Req_WR_Address, Req_WR_Data,
             Req_RD1_Address, Req_RD2_Address,
      input  Grant, RD_Valid, RAM_WR_Enable, RAM_WR_Address, RAM_WR_Data,
             RAM_RD1_Address, RAM_RD2_Address, Hold_Timeout, Illegal_Access
   );

   modport slave (
      input  Req, Req_WR_Enable, Req_WR_Address, Req_WR_Data,
             Req_RD1_Address, Req_RD2_Address,
      output Grant, RD_Valid, RAM_WR_Enable, RAM_WR_Address, RAM_WR_Data,
             RAM_RD1_Address, RAM_RD2_Address, Hold_Timeout, Illegal_Access
   );
endinterface

// File: rtl/step_ram_arbiter_rr_pick3.sv
// Combinational round-robin picker: one-hot grant for the first requester
// at or after ptr, wrapping modulo three.
module rr_pick3 (
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] grant
);
   logic [2:0] idx_s;
   logic       found_s;

   // scan ptr, ptr+1, ptr+2 (mod 3) and take the first active request
   always_comb begin
      grant   = 3'b000;
      found_s = 1'b0;
      idx_s   = 3'd0;
      for (int i = 0; i < 3; i++) begin
         idx_s = {1'b0, ptr} + 3'(i);
         if (idx_s >= 3'd3) begin
            idx_s = idx_s - 3'd3;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req[idx_s[1:0]]) begin
            grant[idx_s[1:0]] = 1'b1;
            found_s           = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end
endmodule

// File: rtl/step_ram_arbiter.sv
// Step RAM arbiter: round-robin, lock-until-release ownership of the RAM ports
// with a one-cycle turnaround, owner-tagged read returns and sticky fault flags.
module step_ram_arbiter
   import step_pkg::*;
#(
   parameter int RAM_ADDRESS_WIDTH = STEP_RAM_ADDRESS_WIDTH,
   parameter int DATA_WIDTH        = STEP_DATA_WIDTH,
   parameter int RD_LATENCY        = 1,
   parameter int MAX_HOLD          = 1024
) (
   input  logic               CLK,
   input  logic               RST,
   step_ram_arbiter_if.slave  bus
);
   localparam int AW     = RAM_ADDRESS_WIDTH;
   localparam int DW     = DATA_WIDTH;
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_e          state_r;
   logic [2:0]          grant_r;
   logic [1:0]          owner_r;
   logic [1:0]          ptr_r;
   logic [HOLD_W-1:0]   hold_cnt_r;
   logic [1:0]          tag_pipe_r [RD_LATENCY];
   logic [2:0]          rd_valid_r;
   logic                ram_wr_en_r;
   logic [AW-1:0]       ram_wr_addr_r;
   logic [DW-1:0]       ram_wr_data_r;
   logic [AW-1:0]       ram_rd1_addr_r;
   logic [AW-1:0]       ram_rd2_addr_r;
   logic                hold_timeout_r;
   logic                illegal_r;

   logic [2:0]          pick_s;
   logic [HOLD_W-1:0]   hold_next_s;
   logic                others_wait_s;

   rr_pick3 u_pick (
      .req   (bus.Req),
      .ptr   (ptr_r),
      .grant (pick_s)
   );

   assign hold_next_s   = (hold_cnt_r == HOLD_W'(MAX_HOLD)) ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);
   assign others_wait_s = |(bus.Req & ~grant_r);

   // ownership FSM, RAM port registers, hold counter and timeout flag
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r        <= ST_IDLE;
         grant_r        <= 3'b000;
         owner_r        <= REQ_IO;
         ptr_r          <= 2'd0;
         hold_cnt_r     <= '0;
         ram_wr_en_r    <= 1'b0;
         ram_wr_addr_r  <= '0;
         ram_wr_data_r  <= '0;
         ram_rd1_addr_r <= '0;
         ram_rd2_addr_r <= '0;
         hold_timeout_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ram_wr_en_r    <= 1'b0;
               ram_wr_addr_r  <= '0;
               ram_wr_data_r  <= '0;
               ram_rd1_addr_r <= '0;
               ram_rd2_addr_r <= '0;
               hold_cnt_r     <= '0;
               if (|bus.Req) begin
                  state_r <= ST_OWN;
                  grant_r <= pick_s;
                  owner_r <= onehot_to_id(pick_s);
               end else begin
                  state_r <= ST_IDLE;
                  grant_r <= 3'b000;
               end
            end
            ST_OWN: begin
               ram_wr_en_r    <= bus.Req_WR_Enable[owner_r] & grant_r[owner_r];
               ram_wr_addr_r  <= bus.Req_WR_Address[owner_r*AW +: AW];
               ram_wr_data_r  <= bus.Req_WR_Data[owner_r*DW +: DW];
               ram_rd1_addr_r <= bus.Req_RD1_Address[owner_r*AW +: AW];
               ram_rd2_addr_r <= bus.Req_RD2_Address[owner_r*AW +: AW];
               hold_cnt_r     <= hold_next_s;
               // no preemption: a long hold is only reported
               if ((hold_next_s == HOLD_W'(MAX_HOLD)) && others_wait_s) begin
                  hold_timeout_r <= 1'b1;
               end else begin
                  hold_timeout_r <= hold_timeout_r;
               end
               if (!bus.Req[owner_r]) begin
                  state_r <= ST_IDLE;
                  grant_r <= 3'b000;
                  ptr_r   <= next_id(owner_r);
               end else begin
                  state_r <= ST_OWN;
                  grant_r <= grant_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               grant_r <= 3'b000;
            end
         endcase
      end
   end

   // read-return tag pipe aligned with RAM read latency, plus illegal-write flag
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_pipe_r[i] <= TAG_NONE;
         end
         rd_valid_r <= 3'b000;
         illegal_r  <= 1'b0;
      end else begin
         tag_pipe_r[0] <= (state_r == ST_OWN) ? owner_r : TAG_NONE;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_pipe_r[i] <= tag_pipe_r[i-1];
         end
         rd_valid_r <= tag_to_onehot(tag_pipe_r[RD_LATENCY-1]);
         if (|(bus.Req_WR_Enable & ~grant_r)) begin
            illegal_r <= 1'b1;
         end else begin
            illegal_r <= illegal_r;
         end
      end
   end

   assign bus.Grant           = grant_r;
   assign bus.RD_Valid        = rd_valid_r;
   assign bus.RAM_WR_Enable   = ram_wr_en_r;
   assign bus.RAM_WR_Address  = ram_wr_addr_r;
   assign bus.RAM_WR_Data     = ram_wr_data_r;
   assign bus.RAM_RD1_Address = ram_rd1_addr_r;
   assign bus.RAM_RD2_Address = ram_rd2_addr_r;
   assign bus.Hold_Timeout    = hold_timeout_r;
   assign bus.Illegal_Access  = illegal_r;
endmodule

// File: tb/tb_step_ram_arbiter.sv
// Directed bench for step_ram_arbiter with RD_LATENCY=2 and MAX_HOLD=8.
module tb_step_ram_arbiter;
   import step_pkg::*;

   localparam int AW = 13;
   localparam int DW = 64;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [2:0] req_tab [10];
   logic [2:0] gnt_exp [10];

   always #5 CLK = ~CLK;

   step_ram_arbiter_if #(.RAM_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   step_ram_arbiter #(
      .RAM_ADDRESS_WIDTH (AW),
      .DATA_WIDTH        (DW),
      .RD_LATENCY        (2),
      .MAX_HOLD          (8)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.Req             = 3'b000;
      bus.Req_WR_Enable   = 3'b000;
      bus.Req_WR_Address  = '0;
      bus.Req_WR_Data     = '0;
      bus.Req_RD1_Address = '0;
      bus.Req_RD2_Address = '0;
   endtask

   task automatic set_fields(input int k, input logic we, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd, input logic [AW-1:0] r1,
                             input logic [AW-1:0] r2);
      bus.Req_WR_Enable[k]           = we;
      bus.Req_WR_Address[k*AW +: AW] = wa;
      bus.Req_WR_Data[k*DW +: DW]    = wd;
      bus.Req_RD1_Address[k*AW +: AW] = r1;
      bus.Req_RD2_Address[k*AW +: AW] = r2;
   endtask

   task automatic do_reset();
      RST = 1'b0;
      clear_inputs();
      step();
      step();
      RST = 1'b1;
   endtask

   initial begin
      req_tab = '{3'b111, 3'b110, 3'b111, 3'b111, 3'b101, 3'b111, 3'b111, 3'b011, 3'b111, 3'b111};
      gnt_exp = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};

      // reset held with all requests active
      clear_inputs();
      RST = 1'b0;
      bus.Req = 3'b111;
      repeat (3) step();
      check_val("rst_grant", 64'(bus.Grant), 64'h0);
      check_val("rst_wren", 64'(bus.RAM_WR_Enable), 64'h0);
      check_val("rst_timeout", 64'(bus.Hold_Timeout), 64'h0);
      check_val("rst_illegal", 64'(bus.Illegal_Access), 64'h0);
      check_val("rst_rdvalid", 64'(bus.RD_Valid), 64'h0);
      RST = 1'b1;
      step();
      check_val("rst_first_grant", 64'(bus.Grant), 64'h1);

      // single owner: write 0xA5 to 5, then read 5
      do_reset();
      bus.Req = 3'b010;
      set_fields(1, 1'b1, 13'd5, 64'hA5, 13'd0, 13'd0);
      step();
      check_val("so_grant", 64'(bus.Grant), 64'h2);
      check_val("so_idle_wren", 64'(bus.RAM_WR_Enable), 64'h0);
      step();
      check_val("so_wren", 64'(bus.RAM_WR_Enable), 64'h1);
      check_val("so_waddr", 64'(bus.RAM_WR_Address), 64'd5);
      check_val("so_wdata", bus.RAM_WR_Data, 64'hA5);
      set_fields(1, 1'b0, 13'd0, 64'h0, 13'd5, 13'd5);
      step();
      check_val("so_rd1", 64'(bus.RAM_RD1_Address), 64'd5);
      check_val("so_rd2", 64'(bus.RAM_RD2_Address), 64'd5);
      check_val("so_rd_wren", 64'(bus.RAM_WR_Enable), 64'h0);
      check_val("so_rdv_early", 64'(bus.RD_Valid), 64'h0);
      bus.Req = 3'b000;
      step();
      check_val("so_release", 64'(bus.Grant), 64'h0);
      step();
      check_val("so_rdvalid", 64'(bus.RD_Valid), 64'h2);
      step();
      step();
      check_val("so_rdv_done", 64'(bus.RD_Valid), 64'h0);
      check_val("so_idle_rd1", 64'(bus.RAM_RD1_Address), 64'd0);

      // contention: every owner releases after two grant cycles
      do_reset();
      bus.Req = 3'b111;
      for (int i = 0; i < 10; i++) begin
         step();
         check_val($sformatf("rr_grant%0d", i), 64'(bus.Grant), 64'(gnt_exp[i]));
         bus.Req = req_tab[i];
      end
      // asynchronous reset in the middle of owner 0's burst
      check_val("rr_rdv_owner2", 64'(bus.RD_Valid), 64'h4);
      RST = 1'b0;
      #1;
      check_val("midrst_grant", 64'(bus.Grant), 64'h0);
      check_val("midrst_rdvalid", 64'(bus.RD_Valid), 64'h0);
      step();
      RST = 1'b1;

      // late return for owner 2 after the grant has moved to owner 0
      do_reset();
      bus.Req = 3'b100;
      step();
      check_val("late_grant2", 64'(bus.Grant), 64'h4);
      bus.Req = 3'b101;
      set_fields(2, 1'b0, 13'd0, 64'h0, 13'd7, 13'd8);
      step();
      check_val("late_rd1", 64'(bus.RAM_RD1_Address), 64'd7);
      bus.Req = 3'b001;
      step();
      check_val("late_turn", 64'(bus.Grant), 64'h0);
      step();
      check_val("late_grant0", 64'(bus.Grant), 64'h1);
      check_val("late_rdvalid2", 64'(bus.RD_Valid), 64'h4);
      step();
      step();
      check_val("late_idle_tag", 64'(bus.RD_Valid), 64'h0);

      // write from a non-owner is dropped and flagged
      do_reset();
      bus.Req = 3'b010;
      step();
      check_val("ill_grant", 64'(bus.Grant), 64'h2);
      set_fields(2, 1'b1, 13'd9, 64'h3C, 13'd0, 13'd0);
      step();
      check_val("ill_flag", 64'(bus.Illegal_Access), 64'h1);
      step();
      check_val("ill_wren", 64'(bus.RAM_WR_Enable), 64'h0);
      set_fields(2, 1'b0, 13'd0, 64'h0, 13'd0, 13'd0);
      bus.Req = 3'b000;
      repeat (3) step();
      check_val("ill_sticky", 64'(bus.Illegal_Access), 64'h1);
      do_reset();
      check_val("ill_cleared", 64'(bus.Illegal_Access), 64'h0);

      // hold timeout: owner 0 keeps the grant for 10 cycles while 1 waits
      bus.Req = 3'b001;
      step();
      check_val("to_grant", 64'(bus.Grant), 64'h1);
      bus.Req = 3'b011;
      repeat (7) step();
      check_val("to_before", 64'(bus.Hold_Timeout), 64'h0);
      step();
      check_val("to_set", 64'(bus.Hold_Timeout), 64'h1);
      check_val("to_no_preempt", 64'(bus.Grant), 64'h1);
      repeat (2) step();
      check_val("to_still_owner", 64'(bus.Grant), 64'h1);
      bus.Req = 3'b010;
      step();
      check_val("to_release", 64'(bus.Grant), 64'h0);
      step();
      check_val("to_next_owner", 64'(bus.Grant), 64'h2);
      check_val("to_sticky", 64'(bus.Hold_Timeout), 64'h1);
      do_reset();
      check_val("to_cleared", 64'(bus.Hold_Timeout), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
